// File: rtl/time_setter.sv
// Time-setting front end: debounces mode/inc/dec buttons and edits a shadow copy of the running time.
// Optional auto-repeat for held inc/dec buttons is enabled by defining TIME_SETTER_AUTO_REPEAT_EN.
module time_setter #(
  parameter int HOUR            = 24,
  parameter int MINUTE          = 60,
  parameter int SECOND          = 60,
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int REPEAT_CYCLES   = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [23:0] cur_time,
  output logic [23:0] load_time,
  output logic        load,
  output logic        editing,
  output logic [1:0]  field
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [7:0] HOUR_MAX = 8'(HOUR - 1);
  localparam logic [7:0] MIN_MAX  = 8'(MINUTE - 1);
  localparam logic [7:0] SEC_MAX  = 8'(SECOND - 1);

  typedef enum logic [2:0] {IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT} state_t;

  // Button index 0 = mode, 1 = inc, 2 = dec
  logic [2:0]    btn_raw, sync_a, sync_b, deb, deb_q, rise;
  logic [DW-1:0] db_cnt [3];
  logic          mode_ev, inc_ev, dec_ev, adjust;
  state_t        state_q, state_d;
  logic [23:0]   shadow_q, shadow_d;

  assign btn_raw = {btn_dec, btn_inc, btn_mode};
  assign rise    = deb & ~deb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      deb    <= '0;
      deb_q  <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      deb_q  <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] != deb[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]    <= sync_b[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign mode_ev = rise[0];

`ifdef TIME_SETTER_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rep_cnt [2];
  logic [1:0]    rep_pulse;

  // Counter sits at 0 in the press cycle and fires every time it reaches REPEAT_CYCLES
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!deb[i+1])                          rep_cnt[i] <= '0;
        else if (rep_cnt[i] == RW'(REPEAT_CYCLES)) rep_cnt[i] <= RW'(1);
        else                                    rep_cnt[i] <= rep_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    rep_pulse = '0;
    for (int i = 0; i < 2; i++)
      rep_pulse[i] = deb[i+1] && (rep_cnt[i] == RW'(REPEAT_CYCLES));
  end

  assign inc_ev = rise[1] | rep_pulse[0];
  assign dec_ev = rise[2] | rep_pulse[1];
`else
  assign inc_ev = rise[1];
  assign dec_ev = rise[2];
`endif

  function automatic logic [7:0] step(input logic [7:0] v, input logic [7:0] max,
                                      input logic up);
    if (up) return (v == max) ? 8'd0 : v + 8'd1;
    else    return (v == 8'd0) ? max : v - 8'd1;
  endfunction

  // A mode event wins over inc/dec, and inc together with dec cancels out
  assign adjust = !mode_ev && (inc_ev ^ dec_ev);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (mode_ev) begin
          state_d  = EDIT_HOUR;
          shadow_d = cur_time;
        end
      end
      EDIT_HOUR: begin
        if (mode_ev) state_d = EDIT_MIN;
        else if (adjust) shadow_d[23:16] = step(shadow_q[23:16], HOUR_MAX, inc_ev);
      end
      EDIT_MIN: begin
        if (mode_ev) state_d = EDIT_SEC;
        else if (adjust) shadow_d[15:8] = step(shadow_q[15:8], MIN_MAX, inc_ev);
      end
      EDIT_SEC: begin
        if (mode_ev) state_d = COMMIT;
        else if (adjust) shadow_d[7:0] = step(shadow_q[7:0], SEC_MAX, inc_ev);
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // load_time is captured on entry to COMMIT so it is already valid while load is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      load_time <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      if (state_q == EDIT_SEC && mode_ev) load_time <= shadow_q;
    end
  end

  always_comb begin
    load    = (state_q == COMMIT);
    editing = (state_q != IDLE);
    field   = 2'd0;
    case (state_q)
      EDIT_HOUR: field = 2'd1;
      EDIT_MIN:  field = 2'd2;
      EDIT_SEC:  field = 2'd3;
      default:   field = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_time_setter.sv
// Scoreboard bench for time_setter: commits push the expected load_time, a monitor checks each load pulse.
// Expected auto-repeat behaviour follows TIME_SETTER_AUTO_REPEAT_EN.
module tb_time_setter;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_mode, btn_inc, btn_dec;
  logic [23:0] cur_time;
  logic [23:0] load_time;
  logic        load, editing;
  logic [1:0]  field;

  int          checks   = 0;
  int          failures = 0;
  logic [23:0] exp_q [$];
  logic [23:0] exp_val;
  logic        load_prev = 1'b0;

`ifdef TIME_SETTER_AUTO_REPEAT_EN
  localparam logic [7:0] HELD_SEC = 8'd4;
`else
  localparam logic [7:0] HELD_SEC = 8'd1;
`endif

  always #5 clk = ~clk;

  time_setter #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .cur_time (cur_time),
    .load_time(load_time),
    .load     (load),
    .editing  (editing),
    .field    (field)
  );

  // Monitor: every load pulse must match the oldest queued commit and last one cycle
  always @(negedge clk) begin
    if (!rst && load) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL load_unexpected: load_time=%h, no commit was expected", load_time);
      end else begin
        exp_val = exp_q.pop_front();
        if (load_time !== exp_val) begin
          failures++;
          $display("[TB] FAIL load_time: got %h expected %h", load_time, exp_val);
        end
      end
      checks++;
      if (load_prev) begin
        failures++;
        $display("[TB] FAIL load_width: load high for more than one cycle (got 1 expected 0)");
      end
    end
    load_prev <= load;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold the given buttons for 'hold' cycles, then release and let the debouncers settle
  task automatic apply_stimulus(input logic m, input logic i, input logic d, input int hold);
    btn_mode = m;
    btn_inc  = i;
    btn_dec  = d;
    tick(hold);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    tick(12);
  endtask

  task automatic mode_press();
    apply_stimulus(1'b1, 1'b0, 1'b0, 10);
  endtask

  initial begin
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    cur_time = 24'h0;
    tick(3);
    check_output("reset_editing", 32'(editing), 32'd0);
    check_output("reset_field", 32'(field), 32'd0);
    check_output("reset_load", 32'(load), 32'd0);
    check_output("reset_load_time", 32'(load_time), 32'd0);
    rst = 1'b0;
    tick(2);

    // 23:59:58, hour wraps up to 0
    cur_time = 24'h17_3B_3A;
    mode_press();
    check_output("s1_editing", 32'(editing), 32'd1);
    check_output("s1_field_hour", 32'(field), 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 10);
    mode_press();
    check_output("s1_field_min", 32'(field), 32'd2);
    mode_press();
    check_output("s1_field_sec", 32'(field), 32'd3);
    exp_q.push_back(24'h00_3B_3A);
    mode_press();
    check_output("s1_back_idle", 32'(editing), 32'd0);
    check_output("s1_field_none", 32'(field), 32'd0);

    // Minute 0 decrements to 59
    cur_time = 24'h0A_00_05;
    mode_press();
    mode_press();
    check_output("s2_field_min", 32'(field), 32'd2);
    apply_stimulus(1'b0, 1'b0, 1'b1, 10);
    mode_press();
    exp_q.push_back(24'h0A_3B_05);
    mode_press();

    // Short glitch is ignored, a long hold gives exactly one increment
    cur_time = 24'h01_02_03;
    mode_press();
    apply_stimulus(1'b0, 1'b1, 1'b0, 3);
    apply_stimulus(1'b0, 1'b1, 1'b0, 10);
    mode_press();
    mode_press();
    exp_q.push_back(24'h02_02_03);
    mode_press();

    // mode+inc advances without editing; inc+dec together cancels
    cur_time = 24'h05_06_07;
    mode_press();
    apply_stimulus(1'b1, 1'b1, 1'b0, 10);
    check_output("s4_mode_wins_field", 32'(field), 32'd2);
    mode_press();
    apply_stimulus(1'b0, 1'b1, 1'b1, 10);
    check_output("s4_still_sec", 32'(field), 32'd3);
    exp_q.push_back(24'h05_06_07);
    mode_press();

    // Held inc in EDIT_SEC from 0 for 30 debounced cycles
    cur_time = 24'h03_04_00;
    mode_press();
    mode_press();
    mode_press();
    apply_stimulus(1'b0, 1'b1, 1'b0, 30);
    exp_q.push_back({16'h03_04, HELD_SEC});
    mode_press();

    // Wrap boundaries: hour 0 down to 23, minute and second 59 up to 0
    cur_time = 24'h00_3B_3B;
    mode_press();
    apply_stimulus(1'b0, 1'b0, 1'b1, 10);
    mode_press();
    apply_stimulus(1'b0, 1'b1, 1'b0, 10);
    mode_press();
    apply_stimulus(1'b0, 1'b1, 1'b0, 10);
    exp_q.push_back(24'h17_00_00);
    mode_press();

    // Reset in EDIT_MIN aborts the edit and clears load_time
    cur_time = 24'h09_09_09;
    mode_press();
    mode_press();
    check_output("s7_field_min", 32'(field), 32'd2);
    apply_stimulus(1'b0, 1'b1, 1'b0, 10);
    rst = 1'b1;
    tick(2);
    check_output("s7_rst_editing", 32'(editing), 32'd0);
    check_output("s7_rst_field", 32'(field), 32'd0);
    check_output("s7_rst_load", 32'(load), 32'd0);
    check_output("s7_rst_load_time", 32'(load_time), 32'd0);
    rst = 1'b0;
    tick(20);
    check_output("s7_after_editing", 32'(editing), 32'd0);
    check_output("s7_after_load_time", 32'(load_time), 32'd0);

    // Button held across reset is debounced again from 0 after release
    btn_mode = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    check_output("s8_not_yet", 32'(editing), 32'd0);
    tick(6);
    check_output("s8_editing", 32'(editing), 32'd1);
    check_output("s8_field_hour", 32'(field), 32'd1);
    btn_mode = 1'b0;
    tick(12);

    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
